// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_bank switch debouncers.
package debounce_pkg;

    // 10 ms at 50 MHz
    localparam int DEFAULT_STABLE_CYCLES = 500000;

    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: 2-flop synchroniser, stability counter, edge strobes.
// Strobe logic is present only when DEBOUNCE_EDGE_STROBE_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic sw_in,
    output logic sw_out,
    output logic sw_rise,
    output logic sw_fall,
    output logic edge_nxt
);

    localparam int             CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q, out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qual;

    // The counter only runs while the sampled level disagrees with the output,
    // so any return to the current level discards all accumulated credit.
    always_comb begin
        qual  = (sync2_q != out_q) && (cnt_q == CNT_MAX);
        out_d = qual ? sync2_q : out_q;
        cnt_d = '0;
        if (sync2_q != out_q && !qual)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= INIT_LEVEL;
            sync2_q <= INIT_LEVEL;
            out_q   <= INIT_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_out = out_q;

`ifdef DEBOUNCE_EDGE_STROBE_EN
    logic rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        rise_d = qual & sync2_q;
        fall_d = qual & ~sync2_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;
    assign edge_nxt = qual;
`else
    assign sw_rise  = 1'b0;
    assign sw_fall  = 1'b0;
    assign edge_nxt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent switch debouncers with a shared any_edge flag.
// DEBOUNCE_EDGE_STROBE_EN enables sw_rise/sw_fall/any_edge; otherwise they are 0.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   CHANNELS      = 8,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [CHANNELS-1:0] sw_in,
    output logic [CHANNELS-1:0] sw_out,
    output logic [CHANNELS-1:0] sw_rise,
    output logic [CHANNELS-1:0] sw_fall,
    output logic                any_edge
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("debounce_bank: CHANNELS must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_bank: STABLE_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] edge_nxt;
    logic                any_edge_q, any_edge_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INIT_LEVEL    (INIT_LEVEL)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .sw_in    (sw_in[i]),
            .sw_out   (sw_out[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i]),
            .edge_nxt (edge_nxt[i])
        );
    end

    // Built from the channels' next-state qualify terms so it lands with the strobes.
    always_comb any_edge_d = |edge_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) any_edge_q <= 1'b0;
        else         any_edge_q <= any_edge_d;
    end

    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: reference model pushes expectations, monitor compares.
module tb_debounce_bank;

    localparam int   CH   = 4;
    localparam int   SC   = 8;
    localparam logic INIT = 1'b0;
`ifdef DEBOUNCE_EDGE_STROBE_EN
    localparam bit STROBES = 1'b1;
`else
    localparam bit STROBES = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [CH-1:0] sw_in = '1;
    logic [CH-1:0] sw_out, sw_rise, sw_fall;
    logic          any_edge;

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(SC), .INIT_LEVEL(INIT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sw_in    (sw_in),
        .sw_out   (sw_out),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .any_edge (any_edge)
    );

    typedef struct packed {
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          any;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: the level seen by the debouncer at an edge is the pin as it was
    // two edges earlier; the output flips once the last SC seen levels all differ.
    logic [CH-1:0] p1, p2, m_out, seen, nxt;
    logic [CH-1:0] hist[$];
    exp_t          e_mod, e_mon;
    bit            all_diff;

    always @(posedge clk) begin
        if (!resetn) begin
            p1    = {CH{INIT}};
            p2    = {CH{INIT}};
            m_out = {CH{INIT}};
            hist.delete();
            e_mod = '{out: {CH{INIT}}, rise: '0, fall: '0, any: 1'b0};
        end else begin
            seen = p2;
            p2   = p1;
            p1   = sw_in;
            hist.push_back(seen);
            if (hist.size() > SC) void'(hist.pop_front());
            nxt = m_out;
            for (int c = 0; c < CH; c++) begin
                if (hist.size() == SC) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][c] == m_out[c]) all_diff = 1'b0;
                    if (all_diff) nxt[c] = ~m_out[c];
                end
            end
            e_mod.out  = nxt;
            e_mod.rise = STROBES ? (nxt & ~m_out) : '0;
            e_mod.fall = STROBES ? (~nxt & m_out) : '0;
            e_mod.any  = |(e_mod.rise | e_mod.fall);
            m_out = nxt;
        end
        sb.push_back(e_mod);
    end

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e_mon = sb.pop_front();
            n_cmp++;
            if (sw_out !== e_mon.out) begin
                n_bad++;
                $display("FAIL sw_out @%0t: got %b want %b", $time, sw_out, e_mon.out);
            end
            n_cmp++;
            if ({sw_rise, sw_fall, any_edge} !== {e_mon.rise, e_mon.fall, e_mon.any}) begin
                n_bad++;
                $display("FAIL strobes @%0t: got rise=%b fall=%b any=%b want rise=%b fall=%b any=%b",
                         $time, sw_rise, sw_fall, any_edge, e_mon.rise, e_mon.fall, e_mon.any);
            end
        end
    end

    // Pin value v is seen by exactly n rising edges.
    task automatic hold(input logic [CH-1:0] v, input int n);
        @(negedge clk);
        #1 sw_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_now(input string tag);
        n_cmp++;
        if (sw_out !== {CH{INIT}} || sw_rise !== '0 || sw_fall !== '0 || any_edge !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got out=%b rise=%b fall=%b any=%b want out=%b and no strobes",
                     tag, sw_out, sw_rise, sw_fall, any_edge, {CH{INIT}});
        end
    endtask

    initial begin
        // reset held with all pins high
        hold(4'hF, 3);
        check_reset_now("reset_hold");
        @(negedge clk);
        #1 resetn = 1'b1;
        hold(4'hF, 14);

        // bounce on ch0, then settle high
        hold(4'h0, 14);
        for (int i = 0; i < 14; i++) hold((i % 2) ? 4'h1 : 4'h0, 3);
        hold(4'h1, 14);

        // threshold boundary: 7-cycle pulse ignored, 8-cycle pulse accepted
        hold(4'h0, 14);
        hold(4'h1, 7);
        hold(4'h0, 14);
        hold(4'h1, 8);
        hold(4'h0, 14);

        // simultaneous rise on ch1 and fall on ch2
        hold(4'b0100, 14);
        hold(4'b0010, 14);
        hold(4'h0, 14);

        // reset while ch3 is mid-count
        hold(4'b1000, 7);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 check_reset_now("reset_midcount");
        hold(4'b1000, 3);
        @(negedge clk);
        #1 resetn = 1'b1;
        hold(4'b1000, 14);
        hold(4'h0, 14);

        // randomized pin activity, short and long holds mixed
        for (int i = 0; i < 80; i++)
            hold(CH'($urandom), $urandom_range(1, 12));
        hold(4'h0, 14);

        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
